branch_resolve_queue: RTL

- Age-ordered buffer between the execute-stage branch units and the gselect branch predictor's training port.
- Each cycle it accepts up to `N` resolved branches and retires up to DRAIN of them, oldest first, as predictor update packets.
- Meters predictor training so that at most DRAIN counter updates land per cycle.
- Applies backpressure to execute when it is nearly full.

---
 rtl/branch_resolve_queue_pkg.sv | 26 ++
 rtl/branch_resolve_queue_if.sv | 14 +
 rtl/branch_resolve_queue_lane_compactor.sv | 19 +
 rtl/branch_resolve_queue.sv | 86 ++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// branch_resolve_queue_pkg: shared predictor packet type, queue sizing constants and pointer type
`ifndef N
`define N 3
`endif
package branch_resolve_queue_pkg;

    localparam int BP_INDEX_BITS = 8;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              pc;
        logic [BP_INDEX_BITS-1:0] bp_indicies;
        logic                     taken;
    } BRANCH_PREDICTION_PACKET;

    localparam int BRQ_DEPTH = 8;
    localparam int BRQ_DRAIN = 2;
    localparam int BRQ_PTR_W = $clog2(BRQ_DEPTH) + 1;

    typedef logic [BRQ_PTR_W-1:0] BRQ_PTR;

    function automatic int brq_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: execute-side enqueue lanes and predictor-side training lanes
interface branch_resolve_queue_if
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH
);
    BRANCH_PREDICTION_PACKET in_resolve [`N];
    logic                    in_ready;
    BRANCH_PREDICTION_PACKET out_resolve [`N];
    logic [$clog2(DEPTH):0]  free_count;

    modport master (output in_resolve, input in_ready, input out_resolve, input free_count);
    modport slave  (input in_resolve, output in_ready, output out_resolve, output free_count);
endinterface

// File: rtl/branch_resolve_queue_lane_compactor.sv
// branch_resolve_queue_lane_compactor: prefix popcount giving each valid lane its packed slot offset
module branch_resolve_queue_lane_compactor #(
    parameter int LANES = `N,
    parameter int OW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]         valid,
    output logic [LANES-1:0][OW-1:0] offset,
    output logic [OW-1:0]            total
);
    // running count of valid lanes seen below each lane
    always_comb begin
        total  = '0;
        offset = '0;
        for (int i = 0; i < LANES; i++) begin
            offset[i] = total;
            total     = total + OW'(valid[i]);
        end
    end
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: age-ordered resolve buffer metering predictor training; BRQ_BYPASS_EN enables empty-queue bypass
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int DRAIN = BRQ_DRAIN
) (
    input logic                   clock,
    input logic                   reset,
    branch_resolve_queue_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int OW = $clog2(`N + 1);

    BRANCH_PREDICTION_PACKET mem [DEPTH];
    BRANCH_PREDICTION_PACKET out_next [`N];
    logic [PW-1:0] head, tail, count, count_next, free_next, k, acc, nb, adv;
    logic [`N-1:0] lane_valid;
    logic [`N-1:0][OW-1:0] off;
    logic [OW-1:0] total;
    logic byp;

    branch_resolve_queue_lane_compactor #(.LANES(`N), .OW(OW)) u_compactor (
        .valid  (lane_valid),
        .offset (off),
        .total  (total)
    );

`ifdef BRQ_BYPASS_EN
    assign byp = (count == '0) && bus.in_ready;
`else
    assign byp = 1'b0;
`endif

    // occupancy bookkeeping: drain from pre-enqueue contents, bypassed entries skip storage residency
    always_comb begin
        for (int i = 0; i < `N; i++) lane_valid[i] = bus.in_resolve[i].valid;
        count      = tail - head;
        k          = PW'(brq_min(int'(count), DRAIN));
        acc        = bus.in_ready ? PW'(total) : '0;
        nb         = byp ? PW'(brq_min(int'(acc), DRAIN)) : '0;
        adv        = k + nb;
        count_next = count + acc - adv;
        free_next  = PW'(DEPTH) - count_next;
    end

    // oldest k entries to the low lanes, bypassed inputs fill in when the queue was empty
    always_comb begin
        for (int j = 0; j < `N; j++) begin
            out_next[j] = '0;
            if (PW'(j) < k) out_next[j] = mem[head[IW-1:0] + IW'(j)];
        end
        for (int i = 0; i < `N; i++)
            if (byp && lane_valid[i] && int'(off[i]) < DRAIN) out_next[off[i]] = bus.in_resolve[i];
    end

    // compacted write of accepted lanes at tail; bypassed lanes are written too and skipped by head
    always_ff @(posedge clock) begin
        if (reset && bus.in_ready)
            for (int i = 0; i < `N; i++)
                if (lane_valid[i]) mem[tail[IW-1:0] + IW'(off[i])] <= bus.in_resolve[i];
    end

    // pointers and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            head            <= '0;
            tail            <= '0;
            bus.in_ready    <= 1'b1;
            bus.free_count  <= PW'(DEPTH);
            for (int j = 0; j < `N; j++) bus.out_resolve[j] <= '0;
        end else begin
            head            <= head + adv;
            tail            <= tail + acc;
            bus.in_ready    <= free_next >= PW'(`N);
            bus.free_count  <= free_next;
            bus.out_resolve <= out_next;
        end
    end

    // execute must hold its lanes while the queue is not ready
    always_ff @(posedge clock) begin
        if (reset && !bus.in_ready) assert (lane_valid == '0);
    end
endmodule
